// File: rtl/seg_scan_driver.sv
// Four-digit active-low 7-segment scanner with staging/display banks and tear-free commit at frame boundary.
// Latency: an/seg/frame_start are registered, one cycle behind the internal slot/cnt; commit visible on next frame_start.
// Backpressure: none; staging writes and commit requests are always accepted. Optional blanking via SEG_SCAN_BLANK_EN.
module seg_scan_driver #(
   parameter int DIGIT_TICKS = 100000,
   parameter int BLANK_TICKS = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [1:0] wr_digit,
   input  logic [7:0] wr_pattern,
   input  logic       commit,
   input  logic [3:0] digit_en,
   output logic       commit_pending,
   output logic       frame_start,
   output logic [3:0] an,
   output logic [7:0] seg
);

   localparam int               CNT_W     = $clog2(DIGIT_TICKS);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_TICKS - 1);
   localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK_TICKS);
`ifdef SEG_SCAN_BLANK_EN
   localparam bit               BLANK_EN  = 1'b1;
`else
   localparam bit               BLANK_EN  = 1'b0;
`endif

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       slot_q, slot_d;
   logic [7:0]       stage_q [4];
   logic [7:0]       stage_d [4];
   logic [7:0]       disp_q  [4];
   logic [7:0]       disp_d  [4];
   logic             pend_q, pend_d;
   logic [3:0]       an_q, an_d;
   logic [7:0]       seg_q, seg_d;
   logic             fs_q, fs_d;

   logic             cnt_wrap;
   logic             frame_wrap;
   logic             do_copy;
   logic             blank;
   logic             drive;

   // Next-state for the scan counters, banks, commit flag and registered display outputs.
   always_comb begin
      cnt_wrap   = (cnt_q == CNT_LAST);
      frame_wrap = cnt_wrap && (slot_q == 2'd3);
      // A commit arriving on the boundary cycle itself is honoured immediately.
      do_copy    = frame_wrap && (pend_q || commit);

      cnt_d  = cnt_wrap ? '0 : cnt_q + 1'b1;
      slot_d = cnt_wrap ? slot_q + 2'd1 : slot_q;

      stage_d = stage_q;
      if (wr_en) begin
         stage_d[wr_digit] = wr_pattern;
      end

      // Copy reads the pre-write staging values, so a same-edge write waits for the next commit.
      disp_d = do_copy ? stage_q : disp_q;
      pend_d = do_copy ? 1'b0 : (pend_q | commit);

      blank = BLANK_EN && (cnt_q < BLANK_CNT);
      drive = digit_en[slot_q] && !blank;

      an_d  = 4'hF;
      seg_d = 8'hFF;
      if (drive) begin
         an_d  = ~(4'b0001 << slot_q);
         seg_d = disp_q[slot_q];
      end
      fs_d = (slot_q == 2'd0) && (cnt_q == '0);
   end

   // State and output registers with synchronous reset to a dark, idle display.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         slot_q <= 2'd0;
         for (int i = 0; i < 4; i++) begin
            stage_q[i] <= 8'hFF;
            disp_q[i]  <= 8'hFF;
         end
         pend_q <= 1'b0;
         an_q   <= 4'hF;
         seg_q  <= 8'hFF;
         fs_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         slot_q  <= slot_d;
         stage_q <= stage_d;
         disp_q  <= disp_d;
         pend_q  <= pend_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         fs_q    <= fs_d;
      end
   end

   assign commit_pending = pend_q;
   assign frame_start    = fs_q;
   assign an             = an_q;
   assign seg            = seg_q;

endmodule
